// File: rtl/vc_credit_sender_if.sv
// Stream-side handshake bundle for vc_credit_sender: producer val/rdy input,
// valid-only output to the link, and the credit-return strobe from the far end.
interface vc_credit_sender_if #(
  parameter int unsigned p_msg_nbits = 32
);
  logic                   in_val;
  logic                   in_rdy;
  logic [p_msg_nbits-1:0] in_msg;
  logic                   out_val;
  logic [p_msg_nbits-1:0] out_msg;
  logic                   credit_ret;

  // Sender side
  modport slave (
    input  in_val,
    input  in_msg,
    input  credit_ret,
    output in_rdy,
    output out_val,
    output out_msg
  );

  // Producer/link side
  modport master (
    output in_val,
    output in_msg,
    output credit_ret,
    input  in_rdy,
    input  out_val,
    input  out_msg
  );
endinterface

// File: rtl/vc_credit_sender.sv
// Credit-based stream sender. Accepts val/rdy messages and forwards them through
// a registered valid-only output; a credit counter preset to p_credits bounds the
// number of messages outstanding in the downstream buffer.
// Optional feature: define VC_CREDIT_SENDER_STALL_CNT_EN to add a saturating
// 16-bit stall_cnt output counting RUN cycles with in_val && !in_rdy.
module vc_credit_sender #(
  parameter int unsigned p_msg_nbits    = 32,
  parameter int unsigned p_credits      = 4,
  parameter int unsigned p_credit_nbits = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  vc_credit_sender_if.slave         bus,
  output logic [p_credit_nbits-1:0] credits,
  output logic                      credits_zero,
  output logic                      credit_err
`ifdef VC_CREDIT_SENDER_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam logic [p_credit_nbits-1:0] CreditsMax = p_credit_nbits'(p_credits);
  localparam logic [p_credit_nbits-1:0] CreditOne  = p_credit_nbits'(1);

  typedef enum logic {StInit, StRun} state_e;

  state_e                    state_q, state_d;
  logic [p_credit_nbits-1:0] credits_q, credits_d;
  logic                      err_q, err_d;
  logic                      out_val_q;
  logic [p_msg_nbits-1:0]    out_msg_q;
  logic                      run;
  logic                      fire;

  // State register; INIT lasts exactly one cycle after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StInit;
    else        state_q <= state_d;
  end

  // Next state, handshake and credit bookkeeping
  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    err_d     = err_q;
    run       = 1'b0;
    unique case (state_q)
      StInit: state_d = StRun;
      StRun:  run = 1'b1;
      default: state_d = StInit;
    endcase
    // in_rdy depends on registered state only, so a same-cycle return cannot unblock
    bus.in_rdy = run && (credits_q != '0);
    fire       = bus.in_val && bus.in_rdy;
    if (run) begin
      if (fire && !bus.credit_ret) begin
        credits_d = credits_q - CreditOne;
      end else if (!fire && bus.credit_ret) begin
        // A return with nothing outstanding is a protocol error; saturate instead
        if (credits_q == CreditsMax) err_d = 1'b1;
        else                         credits_d = credits_q + CreditOne;
      end
    end
  end

  // Credit counter and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits_q <= CreditsMax;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  // Output register, one cycle latency; message holds between fires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
    end else begin
      out_val_q <= fire;
      if (fire) out_msg_q <= bus.in_msg;
    end
  end

`ifdef VC_CREDIT_SENDER_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the producer was blocked while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (run && bus.in_val && !bus.in_rdy && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign bus.out_val  = out_val_q;
  assign bus.out_msg  = out_msg_q;
  assign credits      = credits_q;
  assign credits_zero = (credits_q == '0);
  assign credit_err   = err_q;

endmodule
